edge_event_arbiter: RTL and testbench

- Multi-channel edge-event controller sitting between asynchronous level inputs and a single event consumer (interrupt/CSR logic).
- Per channel: synchronises the input, detects rising/falling edges under per-channel enable masks, and latches them as pending.
- Shares one registered valid/ready event port among all channels with round-robin arbitration, and flags lost events as overflow.

---
 rtl/edge_evt_pkg.sv | 18 +
 rtl/edge_chan_capture.sv | 51 +++++
 rtl/edge_event_arbiter.sv | 107 ++++++++++
 tb/tb_edge_event_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_evt_pkg.sv
// Shared types for the edge-event controller.
// The FSM state and the presented-event record live here.
package edge_evt_pkg;

    localparam int CH_MAX_W = 5;

    typedef enum logic {
        IDLE,
        VALID
    } state_t;

    typedef struct packed {
        logic [CH_MAX_W-1:0] ch;
        logic                rise;
        logic                fall;
    } evt_t;

endpackage

// File: rtl/edge_chan_capture.sv
// One channel: synchroniser, edge detect, pending latch and sticky overflow.
module edge_chan_capture (
    input  logic clk,
    input  logic reset,
    input  logic a,
    input  logic rise_en,
    input  logic fall_en,
    input  logic load,
    input  logic ovf_clr,
    output logic pend_r,
    output logic pend_f,
    output logic ovf
);

    logic s1, s2, prev;
    logic rise_det, fall_det;
    logic ovf_set;

    assign rise_det = s2 & ~prev & rise_en;
    assign fall_det = ~s2 & prev & fall_en;
    // A detect in the load cycle refills the bit, so only an unloaded hit is lost
    assign ovf_set = ~load & ((rise_det & pend_r) | (fall_det & pend_f));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            prev   <= 1'b0;
            pend_r <= 1'b0;
            pend_f <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            s1   <= a;
            s2   <= s1;
            prev <= s2;
            if (rise_det)
                pend_r <= 1'b1;
            else if (load || !rise_en)
                pend_r <= 1'b0;
            if (fall_det)
                pend_f <= 1'b1;
            else if (load || !fall_en)
                pend_f <= 1'b0;
            if (ovf_set)
                ovf <= 1'b1;
            else if (ovf_clr)
                ovf <= 1'b0;
        end
    end

endmodule

// File: rtl/edge_event_arbiter.sv
// Multi-channel edge-event controller with a round-robin shared event port.
module edge_event_arbiter
    import edge_evt_pkg::*;
#(
    parameter  int NUM_CH = 4,
    localparam int CH_W   = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] a_i,
    input  logic [NUM_CH-1:0] rise_en,
    input  logic [NUM_CH-1:0] fall_en,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [CH_W-1:0]   evt_ch,
    output logic              evt_rise,
    output logic              evt_fall,
    output logic [NUM_CH-1:0] ovf,
    input  logic [NUM_CH-1:0] ovf_clr
);

    localparam logic [NUM_CH-1:0] ONE = {{(NUM_CH-1){1'b0}}, 1'b1};

    logic [NUM_CH-1:0] pend_r, pend_f, pend, load;
    logic [CH_W-1:0]   rr_ptr, winner, idx, next_ptr;
    logic              found, take;
    state_t            state;
    evt_t              evt_q, evt_nxt;
    logic              unused_ch;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        edge_chan_capture u_cap (
            .clk     (clk),
            .reset   (reset),
            .a       (a_i[c]),
            .rise_en (rise_en[c]),
            .fall_en (fall_en[c]),
            .load    (load[c]),
            .ovf_clr (ovf_clr[c]),
            .pend_r  (pend_r[c]),
            .pend_f  (pend_f[c]),
            .ovf     (ovf[c])
        );
    end

    assign pend = pend_r | pend_f;

    // First pending channel at or after rr_ptr, wrapping to 0
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (int'(rr_ptr) + i >= NUM_CH)
                idx = CH_W'(int'(rr_ptr) + i - NUM_CH);
            else
                idx = CH_W'(int'(rr_ptr) + i);
            if (!found && pend[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    assign take     = found && (state == IDLE || evt_ready);
    assign load     = take ? (ONE << winner) : '0;
    assign next_ptr = (winner == CH_W'(NUM_CH - 1)) ? '0 : winner + 1'b1;
    assign evt_nxt  = '{ch:   CH_MAX_W'(winner),
                        rise: pend_r[winner],
                        fall: pend_f[winner]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            evt_q  <= '0;
            rr_ptr <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (found) begin
                        evt_q  <= evt_nxt;
                        rr_ptr <= next_ptr;
                        state  <= VALID;
                    end
                end
                VALID: begin
                    if (evt_ready) begin
                        if (found) begin
                            evt_q  <= evt_nxt;
                            rr_ptr <= next_ptr;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign evt_valid = (state == VALID);
    assign evt_ch    = evt_q.ch[CH_W-1:0];
    assign evt_rise  = evt_q.rise;
    assign evt_fall  = evt_q.fall;
    assign unused_ch = ^evt_q.ch;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Self-checking bench for edge_event_arbiter (NUM_CH=4).
module tb_edge_event_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] a_i, rise_en, fall_en, ovf, ovf_clr;
    logic       evt_valid, evt_ready, evt_rise, evt_fall;
    logic [1:0] evt_ch;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [1:0] ch;
        logic       r;
        logic       f;
    } ev_t;

    typedef struct {
        logic [3:0] a;
        logic [3:0] ren;
        logic [3:0] fen;
        bit         v;
        logic [1:0] ch;
        bit         r;
        bit         f;
    } vec_t;

    ev_t  exp_q[$];
    vec_t tbl[8];

    edge_event_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .a_i       (a_i),
        .rise_en   (rise_en),
        .fall_en   (fall_en),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_ch    (evt_ch),
        .evt_rise  (evt_rise),
        .evt_fall  (evt_fall),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] ch, input logic r, input logic f);
        ev_t e;
        e.ch = ch;
        e.r  = r;
        e.f  = f;
        exp_q.push_back(e);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 30 && exp_q.size() != 0; i++)
            @(posedge clk);
        #1;
        chk(name, exp_q.size(), 0);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    always @(negedge clk) begin : mon
        ev_t got;
        ev_t want;
        if (!reset && evt_valid && evt_ready) begin
            got = {evt_ch, evt_rise, evt_fall};
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: got ch=%0d r=%0b f=%0b expected none",
                         evt_ch, evt_rise, evt_fall);
            end else begin
                want = exp_q.pop_front();
                chk("event", got, want);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        int   diffs;
        int   seen;
        logic [4:0] cap;

        tbl[0] = '{4'b0001, 4'h0, 4'h1, 1'b0, 2'd0, 1'b0, 1'b0};
        tbl[1] = '{4'b0000, 4'h0, 4'h1, 1'b1, 2'd0, 1'b0, 1'b1};
        tbl[2] = '{4'b0100, 4'hF, 4'h0, 1'b1, 2'd2, 1'b1, 1'b0};
        tbl[3] = '{4'b0110, 4'hF, 4'hF, 1'b1, 2'd1, 1'b1, 1'b0};
        tbl[4] = '{4'b0010, 4'hF, 4'hF, 1'b1, 2'd2, 1'b0, 1'b1};
        tbl[5] = '{4'b0000, 4'hF, 4'h0, 1'b0, 2'd0, 1'b0, 1'b0};
        tbl[6] = '{4'b1000, 4'h8, 4'h0, 1'b1, 2'd3, 1'b1, 1'b0};
        tbl[7] = '{4'b0000, 4'h0, 4'h8, 1'b1, 2'd3, 1'b0, 1'b1};

        // Input high across reset release: one rise event on ch1
        reset     = 1'b1;
        a_i       = 4'b0010;
        rise_en   = 4'hF;
        fall_en   = 4'h0;
        evt_ready = 1'b1;
        ovf_clr   = 4'h0;
        #12;
        chk("rst_outputs", {evt_valid, evt_ch, evt_rise, evt_fall}, 5'd0);
        chk("rst_ovf", ovf, 4'h0);
        push(2'd1, 1'b1, 1'b0);
        @(posedge clk);
        #1 reset = 1'b0;
        tick(3);
        chk("latency_k2", evt_valid, 1'b0);
        tick(1);
        chk("latency_k3", evt_valid, 1'b1);
        drain("reset_event");
        chk("reset_ovf", ovf, 4'h0);

        a_i = 4'h0;
        tick(8);
        for (int i = 0; i < 8; i++) begin
            a_i     = tbl[i].a;
            rise_en = tbl[i].ren;
            fall_en = tbl[i].fen;
            if (tbl[i].v)
                push(tbl[i].ch, tbl[i].r, tbl[i].f);
            tick(8);
            drain($sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d_ovf", i), ovf, 4'h0);
        end

        // Three simultaneous rises, then a wrap-around burst
        a_i     = 4'h0;
        rise_en = 4'hF;
        fall_en = 4'h0;
        pulse_reset();
        tick(2);
        push(2'd0, 1'b1, 1'b0);
        push(2'd2, 1'b1, 1'b0);
        push(2'd3, 1'b1, 1'b0);
        a_i = 4'b1101;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (evt_valid)
                break;
        end
        chk("burst_v0", evt_valid, 1'b1);
        @(negedge clk);
        chk("burst_v1", evt_valid, 1'b1);
        @(negedge clk);
        chk("burst_v2", evt_valid, 1'b1);
        @(negedge clk);
        chk("burst_v3", evt_valid, 1'b0);
        tick(1);
        a_i = 4'h0;
        tick(6);
        push(2'd0, 1'b1, 1'b0);
        push(2'd3, 1'b1, 1'b0);
        a_i = 4'b1001;
        tick(10);
        drain("burst");

        // Stall with ch1 toggling behind a held ch0 event
        fall_en   = 4'hF;
        evt_ready = 1'b0;
        a_i       = 4'b1000;
        tick(6);
        cap = {evt_valid, evt_ch, evt_rise, evt_fall};
        chk("hold_present", cap, 5'b1_00_01);
        diffs = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 0)
                a_i = 4'b1010;
            if (i == 6)
                a_i = 4'b1000;
            if (i == 12)
                a_i = 4'b1010;
            tick(1);
            if ({evt_valid, evt_ch, evt_rise, evt_fall} !== cap)
                diffs++;
        end
        chk("hold_stable", diffs, 0);
        chk("hold_ovf", ovf, 4'b0010);
        ovf_clr = 4'b0010;
        tick(1);
        ovf_clr = 4'h0;
        chk("hold_ovf_clr", ovf, 4'h0);
        push(2'd0, 1'b0, 1'b1);
        push(2'd1, 1'b1, 1'b1);
        evt_ready = 1'b1;
        drain("hold");

        // Fall on ch2 in the very cycle ch2 is loaded
        evt_ready = 1'b0;
        a_i       = 4'b0010;
        tick(6);
        a_i = 4'b0110;
        tick(6);
        push(2'd3, 1'b0, 1'b1);
        push(2'd2, 1'b1, 1'b0);
        push(2'd2, 1'b0, 1'b1);
        a_i = 4'b0010;
        repeat (2) @(posedge clk);
        #1 evt_ready = 1'b1;
        tick(10);
        drain("load_collide");
        chk("load_collide_ovf", ovf, 4'h0);

        // Asynchronous reset with an event presented and more pending
        evt_ready = 1'b0;
        a_i       = 4'b0000;
        tick(6);
        a_i = 4'b1010;
        tick(6);
        chk("pre_reset_valid", evt_valid, 1'b1);
        @(posedge clk);
        #3 reset = 1'b1;
        a_i = 4'h0;
        #1;
        chk("async_reset_out", {evt_valid, evt_ch, evt_rise, evt_fall}, 5'd0);
        chk("async_reset_ovf", ovf, 4'h0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        evt_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            if (evt_valid)
                seen++;
        end
        chk("post_reset_quiet", seen, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
